mul_div_unit: RTL

//  Multi-cycle multiply/divide unit with HI/LO registers; companion to the single-cycle ALU in the E stage.

---
 rtl/mul_div_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; busy stalls the pipeline during mult/div.
// Optional macro MDU_MADD_EN enables madd/maddu (accumulate into {HI,LO}).
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDSel,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MADDU = 3'b111;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_next;
  logic [CW-1:0] count;
  logic [2:0]    op;
  logic [31:0]   a, b;
  logic          accept, is_long, is_div, commit;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        a_mag, b_mag, div_n, div_d, uq, ur;
  logic               neg_q, neg_r;
  logic [63:0]        result;

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    busy       = (state == RUN);
    accept     = start && (state == IDLE);
    is_div     = (MDSel == OP_DIV) || (MDSel == OP_DIVU);
`ifdef MDU_MADD_EN
    is_long    = is_div || (MDSel == OP_MULT) || (MDSel == OP_MULTU) ||
                 (MDSel == OP_MADD) || (MDSel == OP_MADDU);
`else
    is_long    = is_div || (MDSel == OP_MULT) || (MDSel == OP_MULTU);
`endif
    case (state)
      IDLE: if (accept && is_long) state_next = RUN;
      RUN: begin
        if (count == '0) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Signed divide goes through the unsigned divider on magnitudes, which also
  // yields the 8000_0000 / FFFF_FFFF overflow result without special casing.
  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'b0, a} * {32'b0, b};
    a_mag  = a[31] ? (32'd0 - a) : a;
    b_mag  = b[31] ? (32'd0 - b) : b;
    div_n  = (op == OP_DIV) ? a_mag : a;
    div_d  = (op == OP_DIV) ? b_mag : b;
    uq     = (div_d == 32'd0) ? 32'd0 : div_n / div_d;
    ur     = (div_d == 32'd0) ? 32'd0 : div_n % div_d;
    neg_q  = a[31] ^ b[31];
    neg_r  = a[31];
    result = {HI, LO};
    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV: begin
        if (b == 32'd0) result = {a, 32'hFFFF_FFFF};
        else result = {(neg_r ? (32'd0 - ur) : ur), (neg_q ? (32'd0 - uq) : uq)};
      end
      OP_DIVU: begin
        if (b == 32'd0) result = {a, 32'hFFFF_FFFF};
        else result = {ur, uq};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  result = {HI, LO} + prod_s;
      OP_MADDU: result = {HI, LO} + prod_u;
`endif
      default: result = {HI, LO};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      op    <= '0;
      a     <= '0;
      b     <= '0;
      done  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      done <= commit;
      if (commit) begin
        HI <= result[63:32];
        LO <= result[31:0];
      end
      if (accept) begin
        if (is_long) begin
          op    <= MDSel;
          a     <= rs;
          b     <= rt;
          count <= is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
        end else if (MDSel == OP_MTHI) begin
          HI <= rs;
        end else if (MDSel == OP_MTLO) begin
          LO <= rs;
        end
      end else if (state == RUN && count != '0) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule
